// File: rtl/reg_context_xfer_if.sv
// reg_context_xfer_if: request, register-file and stream signals of the context transfer engine
interface reg_context_xfer_if;
    logic        saveReq;
    logic        restoreReq;
    logic        bank;
    logic        busy;
    logic        done;
    logic        regCpuMode;
    logic [4:0]  regReadSelect;
    logic [31:0] regReadData;
    logic        regWriteEnable;
    logic [4:0]  regWriteSelect;
    logic [31:0] regWriteData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    modport slave (
        input  saveReq, restoreReq, bank, regReadData, outReady, inValid, inData,
        output busy, done, regCpuMode, regReadSelect, regWriteEnable, regWriteSelect,
               regWriteData, outValid, outData, inReady
    );
    modport master (
        output saveReq, restoreReq, bank, regReadData, outReady, inValid, inData,
        input  busy, done, regCpuMode, regReadSelect, regWriteEnable, regWriteSelect,
               regWriteData, outValid, outData, inReady
    );
endinterface

// File: rtl/reg_context_xfer.sv
// reg_context_xfer: saves a register bank to an output stream or restores it from an input stream
module reg_context_xfer #(
    parameter int NREGS     = 32,
    parameter int FIRST_REG = 1
) (
    input logic               clk,
    input logic               rst,
    reg_context_xfer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SAVE_READ, SAVE_SEND, RESTORE, WRITE, DONE} state_t;
    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(NREGS - 1);
    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic [31:0] out_data_q, out_data_d;
    logic [4:0]  wr_sel_q, wr_sel_d;
    logic [31:0] wr_data_q, wr_data_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= FIRST;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            wr_sel_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        wr_sel_d   = wr_sel_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            IDLE: if (bus.saveReq || bus.restoreReq) begin
                // save has priority; a simultaneous restore is dropped
                state_d = bus.saveReq ? SAVE_READ : RESTORE;
                idx_d   = FIRST;
                mode_d  = bus.bank;
            end
            SAVE_READ: begin
                out_data_d = bus.regReadData;
                state_d    = SAVE_SEND;
            end
            SAVE_SEND: if (bus.outReady) begin
                state_d = idx_q == LAST ? DONE : SAVE_READ;
                idx_d   = idx_q == LAST ? idx_q : idx_q + 5'd1;
            end
            RESTORE: if (bus.inValid) begin
                wr_data_d = bus.inData;
                wr_sel_d  = idx_q;
                state_d   = WRITE;
            end
            WRITE: begin
                state_d = idx_q == LAST ? DONE : RESTORE;
                idx_d   = idx_q == LAST ? idx_q : idx_q + 5'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign bus.busy           = state_q != IDLE;
    assign bus.done           = state_q == DONE;
    assign bus.regCpuMode     = mode_q;
    assign bus.regReadSelect  = idx_q;
    assign bus.regWriteEnable = state_q == WRITE;
    assign bus.regWriteSelect = wr_sel_q;
    assign bus.regWriteData   = wr_data_q;
    assign bus.outValid       = state_q == SAVE_SEND;
    assign bus.outData        = out_data_q;
    assign bus.inReady        = state_q == RESTORE;
endmodule

// File: tb/tb_reg_context_xfer.sv
// tb_reg_context_xfer: randomized save/restore traffic checked against a bank-content and stream model
module tb_reg_context_xfer;
    localparam int N = 32;
    localparam int F = 1;
    localparam int LIMIT = 3000;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    reg_context_xfer_if bus();
    reg_context_xfer #(.NREGS(N), .FIRST_REG(F)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] rf [2][N];
    logic [31:0] model [2][N];
    logic [31:0] exp_out[$];
    logic [31:0] exp_dat[$];
    logic [4:0]  exp_sel[$];
    logic [31:0] in_q[$];
    logic [31:0] seen[$];
    int errors = 0, checks = 0;
    int out_cnt, wr_cnt, done_cnt, in_ready_cnt, out_valid_cnt, rdy_cnt = 0, out_mode = 0;
    bit in_gaps = 0, in_fire = 0, prev_stall = 0, exp_bank = 0;
    logic [31:0] prev_data;
    assign bus.regReadData = rf[bus.regCpuMode][bus.regReadSelect];
    always @(posedge clk) if (bus.regWriteEnable) rf[bus.regCpuMode][bus.regWriteSelect] <= bus.regWriteData;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (in_fire) void'(in_q.pop_front());
        in_fire = 0;
        bus.inValid = in_q.size() > 0 && (!in_gaps || $urandom_range(0, 2) != 0);
        bus.inData  = in_q.size() > 0 ? in_q[0] : 32'h0;
        bus.outReady = out_mode == 0 ? 1'b1 : out_mode == 1 ? (rdy_cnt % 3 == 2) : 1'($urandom_range(0, 1));
        rdy_cnt++;
    end
    always @(negedge clk) begin
        if (rst) prev_stall = 0;
        else begin
            chk("excl_ready_valid", {31'b0, bus.inReady & bus.outValid}, 0);
            in_fire = bus.inValid & bus.inReady;
            if (bus.inReady) in_ready_cnt++;
            if (bus.done) done_cnt++;
            if (bus.outValid) begin
                out_valid_cnt++;
                chk("save_mode", {31'b0, bus.regCpuMode}, {31'b0, exp_bank});
                if (prev_stall) chk("hold_data", bus.outData, prev_data);
                if (bus.outReady) begin
                    if (exp_out.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL extra_word: got %0d expected none", bus.outData);
                    end else chk("save_word", bus.outData, exp_out.pop_front());
                    seen.push_back(bus.outData);
                    out_cnt++;
                end
            end
            prev_stall = bus.outValid & !bus.outReady;
            prev_data  = bus.outData;
            if (bus.regWriteEnable) begin
                wr_cnt++;
                chk("wr_mode", {31'b0, bus.regCpuMode}, {31'b0, exp_bank});
                if (exp_dat.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_write: got sel %0d expected none", bus.regWriteSelect);
                end else begin
                    chk("wr_sel", {27'b0, bus.regWriteSelect}, {27'b0, exp_sel.pop_front()});
                    chk("wr_data", bus.regWriteData, exp_dat.pop_front());
                end
            end
        end
    end
    task automatic run(input bit sv, input bit rs, input bit b, input int rmode, input bit gaps,
                       input int poke, input bit rnd, output int n);
        logic [31:0] w;
        in_q.delete(); exp_out.delete(); exp_dat.delete(); exp_sel.delete(); seen.delete();
        out_cnt = 0; wr_cnt = 0; done_cnt = 0; in_ready_cnt = 0; out_valid_cnt = 0;
        if (sv) for (int k = F; k < N; k++) exp_out.push_back(model[b][k]);
        else if (rs) for (int k = F; k < N; k++) begin
            w = rnd ? $urandom : k * 1000 + 1;
            in_q.push_back(w); exp_dat.push_back(w); exp_sel.push_back(5'(k));
            model[b][k] = w;
        end
        exp_bank = b;
        @(posedge clk); #1;
        bus.saveReq = sv; bus.restoreReq = rs; bus.bank = b; out_mode = rmode; in_gaps = gaps;
        @(posedge clk); #1;
        bus.saveReq = 0; bus.restoreReq = 0; bus.bank = ~b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.saveReq = n == poke;
        end while (!bus.done && n < LIMIT);
        bus.saveReq = 0;
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL timeout: got no done expected done within %0d cycles", LIMIT);
        end else chk("busy_in_done", {31'b0, bus.busy}, 1);
        @(negedge clk);
        chk("busy_after", {31'b0, bus.busy}, 0);
        chk("done_pulses", done_cnt, 1);
        chk("words_left", exp_out.size(), 0);
        chk("writes_left", exp_dat.size(), 0);
        chk("mode_held", {31'b0, bus.regCpuMode}, {31'b0, b});
    endtask
    initial begin
        int n;
        for (int b = 0; b < 2; b++) for (int k = 0; k < N; k++) begin
            model[b][k] = b == 1 ? k * 1000 + 13 : $urandom;
            rf[b][k] = model[b][k];
        end
        rst = 1; bus.saveReq = 1; bus.restoreReq = 1; bus.bank = 1;
        bus.inValid = 0; bus.inData = 0; bus.outReady = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0; bus.saveReq = 0; bus.restoreReq = 0;
        @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 0);
        chk("rst_done", {31'b0, bus.done}, 0);
        chk("rst_outValid", {31'b0, bus.outValid}, 0);
        chk("rst_inReady", {31'b0, bus.inReady}, 0);
        chk("rst_we", {31'b0, bus.regWriteEnable}, 0);
        chk("rst_rsel", {27'b0, bus.regReadSelect}, F);
        chk("rst_wsel", {27'b0, bus.regWriteSelect}, 0);
        chk("rst_wdata", bus.regWriteData, 0);
        chk("rst_outData", bus.outData, 0);
        chk("rst_mode", {31'b0, bus.regCpuMode}, 0);
        run(1, 0, 1, 0, 0, 0, 0, n);
        chk("save_latency", n - 1, 62);
        chk("save_count", out_cnt, 31);
        chk("first_word", seen[0], 1013);
        chk("last_word", seen[30], 31013);
        run(1, 0, 1, 1, 0, 0, 0, n);
        chk("stall_count", out_cnt, 31);
        run(0, 1, 0, 0, 1, 0, 0, n);
        chk("restore_writes", wr_cnt, 31);
        run(1, 0, 0, 2, 0, 0, 0, n);
        chk("readback_r5", seen[4], 5001);
        run(1, 1, 1, 2, 0, 0, 0, n);
        chk("both_inReady", in_ready_cnt, 0);
        chk("both_writes", wr_cnt, 0);
        chk("both_count", out_cnt, 31);
        exp_out.delete(); seen.delete(); out_cnt = 0; done_cnt = 0;
        for (int k = F; k < N; k++) exp_out.push_back(model[1][k]);
        exp_bank = 1; out_mode = 0;
        @(posedge clk); #1 bus.saveReq = 1; bus.bank = 1;
        @(posedge clk); #1 bus.saveReq = 0;
        n = 0;
        while (out_cnt < 10 && n < LIMIT) begin @(negedge clk); n++; end
        @(posedge clk); #1 rst = 1; exp_out.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_outValid", {31'b0, bus.outValid}, 0);
        chk("mid_rst_busy", {31'b0, bus.busy}, 0);
        chk("mid_rst_rsel", {27'b0, bus.regReadSelect}, F);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, 0);
        run(1, 0, 1, 0, 0, 0, 0, n);
        chk("restart_first", seen[0], 1013);
        run(0, 1, 0, 0, 1, 10, 1, n);
        chk("poke_no_save", out_valid_cnt, 0);
        chk("poke_writes", wr_cnt, 31);
        for (int it = 0; it < 4; it++) begin
            bit sv, b;
            sv = 1'($urandom_range(0, 1));
            b  = 1'($urandom_range(0, 1));
            run(sv, !sv, b, 2, 1, 0, 1, n);
            chk("rand_count", sv ? out_cnt : wr_cnt, 31);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
